// File: rtl/alu_share_ctrl.sv
// Shares one combinational 4-bit ALU between two requesters with round-robin arbitration.
// Latency: accept at edge T, result captured at T+1, response valid from T+1 until the handshake.
// Backpressure: response stalls the FSM in RESP indefinitely; no request is accepted until it drains.
module alu_share_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [3:0]       rsp0_res,
  output logic             rsp0_car,
  output logic             rsp0_of,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [3:0]       rsp1_res,
  output logic             rsp1_car,
  output logic             rsp1_of,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [3:0]       alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       id;
  logic [3:0] res_q;
  logic       car_q;
  logic       of_q;
  logic       grant_vld;
  logic       grant_id;
  logic       accept;
  logic       rsp_done;

  // Round-robin pick: a lone requester wins outright, a tie goes to the one not served last.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and handshake signals; readies are held low while reset is asserted.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld && !rst) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~id;
        rsp1_valid = id;
        if (id ? rsp1_ready : rsp0_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the granted operation into the ALU operand registers and remember who owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_ctrl   <= 3'd0;
      id         <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_a      <= grant_id ? req1_a  : req0_a;
      alu_b      <= grant_id ? req1_b  : req0_b;
      alu_ctrl   <= grant_id ? req1_op : req0_op;
      id         <= grant_id;
      last_grant <= grant_id;
    end
  end

  // Capture the ALU outputs one cycle after accept so the response holds steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= 4'd0;
      car_q <= 1'b0;
      of_q  <= 1'b0;
    end else if (state == EXEC) begin
      res_q <= alu_res;
      car_q <= alu_car;
      of_q  <= alu_of;
    end
  end

  // Count completed response handshakes; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_done) begin
      ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rsp0_res = res_q;
  assign rsp0_car = car_q;
  assign rsp0_of  = of_q;
  assign rsp1_res = res_q;
  assign rsp1_car = car_q;
  assign rsp1_of  = of_q;
  assign busy     = (state != IDLE);

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that shares one combinational 4-bit ALU (op codes 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 compare, 111 equal) between two requesters. It accepts one operation at a time through a valid/ready request port and drives the ALU from registered operands. It captures res/car/of and returns them on the matching response port with valid/ready backpressure. It sits between the requester logic and the ALU instance in the npc lab datapath.

## Interface
- CNT_W, 8, width of the completed-operation counter

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N has an operation pending
- req0_ready / req1_ready  out  1  request N accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  4  operands
- req0_op / req1_op  in  3  ALU op code
- rsp0_valid / rsp1_valid  out  1  result for requester N available
- rsp0_ready / rsp1_ready  in  1  requester N takes the result
- rsp0_res / rsp1_res  out  4  ALU result
- rsp0_car, rsp0_of / rsp1_car, rsp1_of  out  1  carry and overflow flags
- alu_a, alu_b  out  4  ALU operands, registered
- alu_ctrl  out  3  ALU op, registered
- alu_res  in  4; alu_car, alu_of  in  1  ALU outputs
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE, grant selection:
  - only req0_valid: grant 0
  - only req1_valid: grant 1
  - both valid: grant the requester that is not last_grant
  - none valid: stay in IDLE
- IDLE, on a grant:
  - reqN_ready is high (combinational from state and valids); the other ready is low.
  - On the accepting edge: latch a/b/op into alu_a/alu_b/alu_ctrl, store id=N, set last_grant=N, go to EXEC.
- Requesters must not wait for ready before raising valid. a/b/op must be held while valid is high and not yet accepted.
- EXEC: capture alu_res/alu_car/alu_of into the result registers, go to RESP. Both req readies are low.
- RESP:
  - rsp{id}_valid is high; the other rsp valid is low.
  - The result, car and of on both rsp ports come from the result registers and hold stable until the handshake.
  - On rsp{id}_valid & rsp{id}_ready: ops_done increments (wraps from 2^CNT_W−1 to 0), go to IDLE.
  - Both req readies stay low.
- alu_a/alu_b/alu_ctrl keep their last latched values outside an accept edge.
- The block passes ALU flags through unmodified and performs no arithmetic of its own.

## Timing
- Reset values: state IDLE, last_grant=1 (so req0 wins the first tie), alu_a=alu_b=0, alu_ctrl=000, result regs 0, all rsp valids 0, all req readies 0 while rst is high, busy 0, ops_done 0.
- Latency:
  - accept at edge T
  - ALU sees the operands after T; result captured at T+1
  - rsp_valid high from T+1 until the handshake edge
  - Minimum 3 cycles per operation; a new accept is possible in the cycle after the response handshake.
- Simultaneous valids in IDLE: exactly one ready is high. The loser keeps its valid and is granted at the next IDLE, so strict alternation holds under continuous contention.
- Response backpressure stalls the FSM in RESP indefinitely. No request is accepted meanwhile.
- Reset asserted in any state: immediate return to reset values. An in-flight operation and its response are discarded and not counted.
- A requester dropping valid in IDLE without a handshake is legal; no side effects.

## Test plan
- Reset, then req0 add a=0111 b=0001 -> req0_ready high the same cycle; alu_ctrl=000 next cycle; rsp0_valid two edges after accept with res=1000, car=0, of=1; ops_done=1 after rsp0_ready.
- req1 sub a=0101 b=0011 -> rsp1_res=0010, car=1, of=0; rsp0_valid stays 0 throughout.
- req0 and req1 valid in the same cycle right after reset (req0 and 0011/1010, req1 xor 0011/1010) -> req0 served first with res=0010; req1 accepted in the next IDLE with res=1001; with both held valid, grants alternate 0,1,0,1.
- rsp0_ready held low 5 cycles in RESP -> rsp0_valid and res stable for all 5 cycles; req1_ready stays 0; busy=1; completes on the first cycle ready rises.
- rst pulsed during EXEC -> no rsp valid appears; ops_done remains unchanged (0 if first op); next request is served normally, req0 winning a tie.
- 256 back-to-back completed ops with CNT_W=8 -> ops_done reads 255 then wraps to 0.
